// File: rtl/ptp_bridge_pkg.sv
// Shared definitions for the DMA RX admission controller.
//   DMA_ID_WIDTH       : width of the destination DMA channel id
//   drop_ctrl_state_e  : per-packet admission FSM states
package ptp_bridge_pkg;

  localparam int DMA_ID_WIDTH = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PASS = 2'd1,
    DROP = 2'd2
  } drop_ctrl_state_e;

endpackage

// File: rtl/dma_rx_sat_counter.sv
// Saturating event counter used for the per-channel status readback.
//   clk  : system clock
//   rst  : synchronous active-high reset, clears the count
//   inc  : count one event this cycle
//   cnt  : current count, sticks at all-ones instead of wrapping
module dma_rx_sat_counter #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && !(&cnt)) begin
      cnt <= cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/dma_rx_dmux_drop_ctrl.sv
// Per-packet admission controller in front of the DMA RX demux.
// At SOP the destination channel's (registered) queue fill level is compared
// against its CSR threshold; the packet is then either forwarded beat by beat
// with zero latency or sunk entirely, so a full queue never blocks the others.
// Ports:
//   clk, rst                   : clock, synchronous active-high reset
//   igr_valid/ready/data/sop/eop/dest : AVST ingress with channel id
//   egr_valid/ready/data/sop/eop/dest : AVST egress towards the demux
//   q_fill_lvl                 : per-channel queue occupancy
//   cfg_drop_en/threshold      : per-channel drop CSRs
//   stat_drop_cnt/pass_cnt     : per-channel packet counters
//   stat_bad_dest_cnt          : packets whose dest is out of range
module dma_rx_dmux_drop_ctrl
  import ptp_bridge_pkg::*;
#(
  parameter int NUM_DMA    = 3,
  parameter int DATA_WIDTH = 64,
  parameter int LVL_WIDTH  = 16,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         igr_valid,
  output logic                         igr_ready,
  input  logic [DATA_WIDTH-1:0]        igr_data,
  input  logic                         igr_sop,
  input  logic                         igr_eop,
  input  logic [DMA_ID_WIDTH-1:0]      igr_dest,
  output logic                         egr_valid,
  input  logic                         egr_ready,
  output logic [DATA_WIDTH-1:0]        egr_data,
  output logic                         egr_sop,
  output logic                         egr_eop,
  output logic [DMA_ID_WIDTH-1:0]      egr_dest,
  input  logic [NUM_DMA*LVL_WIDTH-1:0] q_fill_lvl,
  input  logic [NUM_DMA-1:0]           cfg_drop_en,
  input  logic [NUM_DMA*LVL_WIDTH-1:0] cfg_drop_threshold,
  output logic [NUM_DMA*CNT_WIDTH-1:0] stat_drop_cnt,
  output logic [NUM_DMA*CNT_WIDTH-1:0] stat_pass_cnt,
  output logic [CNT_WIDTH-1:0]         stat_bad_dest_cnt
);

  drop_ctrl_state_e              state_q, state_d;
  logic [NUM_DMA*LVL_WIDTH-1:0]  fill_r, thr_r;
  logic [NUM_DMA-1:0]            drop_en_r;
  logic [DMA_ID_WIDTH-1:0]       dest_q;
  logic                          dest_ok, over_thr, sop_drop, sop_take;
  logic [NUM_DMA-1:0]            pass_inc, drop_inc;
  logic                          bad_inc;

  // Stage p0: CSR / fill-level snapshot (one cycle of skew is tolerated)
  always_ff @(posedge clk) begin
    fill_r    <= q_fill_lvl;
    thr_r     <= cfg_drop_threshold;
    drop_en_r <= cfg_drop_en;
  end

  // Admission decision for the beat currently presented as SOP
  always_comb begin
    over_thr = 1'b0;
    for (int i = 0; i < NUM_DMA; i++) begin
      if (igr_dest == DMA_ID_WIDTH'(i)) begin
        over_thr = drop_en_r[i] &&
                   (fill_r[i*LVL_WIDTH +: LVL_WIDTH] >= thr_r[i*LVL_WIDTH +: LVL_WIDTH]);
      end
    end
  end

  assign dest_ok  = int'(igr_dest) < NUM_DMA;
  assign sop_drop = !dest_ok || over_thr;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    igr_ready = 1'b0;
    egr_valid = 1'b0;
    sop_take  = 1'b0;
    case (state_q)
      IDLE: begin
        if (igr_valid) begin
          if (igr_sop) begin
            // A forwarded SOP waits for egr_ready; the decision and the count
            // only become final once the beat is actually taken.
            if (sop_drop) begin
              igr_ready = 1'b1;
            end else begin
              igr_ready = egr_ready;
              egr_valid = 1'b1;
            end
            sop_take = igr_ready;
            if (sop_take && !igr_eop) state_d = sop_drop ? DROP : PASS;
          end else begin
            igr_ready = 1'b1;  // framing error: discard silently
          end
        end
      end
      PASS: begin
        if (igr_valid && igr_sop) begin
          state_d = IDLE;  // implicit EOP; SOP is re-evaluated from IDLE
        end else begin
          egr_valid = igr_valid;
          igr_ready = egr_ready;
          if (igr_valid && egr_ready && igr_eop) state_d = IDLE;
        end
      end
      DROP: begin
        if (igr_valid && igr_sop) begin
          state_d = IDLE;
        end else begin
          igr_ready = 1'b1;
          if (igr_valid && igr_eop) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (rst) begin
      igr_ready = 1'b0;
      egr_valid = 1'b0;
      sop_take  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (sop_take) dest_q <= igr_dest;
  end

  assign egr_data = igr_data;
  assign egr_sop  = igr_sop;
  assign egr_eop  = igr_eop;
  // The latch is only loaded as the SOP is taken, so the SOP beat itself
  // reports the live id.
  assign egr_dest = (state_q == IDLE) ? igr_dest : dest_q;

  always_comb begin
    for (int i = 0; i < NUM_DMA; i++) begin
      pass_inc[i] = sop_take && !sop_drop && (igr_dest == DMA_ID_WIDTH'(i));
      drop_inc[i] = sop_take && sop_drop && dest_ok && (igr_dest == DMA_ID_WIDTH'(i));
    end
    bad_inc = sop_take && !dest_ok;
  end

  for (genvar i = 0; i < NUM_DMA; i++) begin : g_ch
    dma_rx_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_drop (
      .clk (clk),
      .rst (rst),
      .inc (drop_inc[i]),
      .cnt (stat_drop_cnt[i*CNT_WIDTH +: CNT_WIDTH])
    );
    dma_rx_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_pass (
      .clk (clk),
      .rst (rst),
      .inc (pass_inc[i]),
      .cnt (stat_pass_cnt[i*CNT_WIDTH +: CNT_WIDTH])
    );
  end

  dma_rx_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_bad (
    .clk (clk),
    .rst (rst),
    .inc (bad_inc),
    .cnt (stat_bad_dest_cnt)
  );

endmodule

// File: tb/tb_dma_rx_dmux_drop_ctrl.sv
// Bench for dma_rx_dmux_drop_ctrl. Forwarded beats are queued as expected
// egress at stimulus time and popped by a monitor on every egress handshake.
// A second instance with 2-bit counters sees identical traffic so that
// counter saturation can be observed in a short run.
module tb_dma_rx_dmux_drop_ctrl;

  localparam int N  = 3;
  localparam int DW = 64;
  localparam int LW = 16;
  localparam int CW = 32;
  localparam int SW = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              igr_valid, igr_ready, igr_sop, igr_eop;
  logic [DW-1:0]     igr_data;
  logic [2:0]        igr_dest;
  logic              egr_valid, egr_ready, egr_sop, egr_eop;
  logic [DW-1:0]     egr_data;
  logic [2:0]        egr_dest;
  logic [N*LW-1:0]   q_fill_lvl, cfg_drop_threshold;
  logic [N-1:0]      cfg_drop_en;
  logic [N*CW-1:0]   stat_drop_cnt, stat_pass_cnt;
  logic [CW-1:0]     stat_bad_dest_cnt;

  logic              s_igr_ready, s_egr_valid, s_egr_sop, s_egr_eop;
  logic [DW-1:0]     s_egr_data;
  logic [2:0]        s_egr_dest;
  logic [N*SW-1:0]   s_drop_cnt, s_pass_cnt;
  logic [SW-1:0]     s_bad_cnt;

  always #5 clk = ~clk;

  dma_rx_dmux_drop_ctrl #(.NUM_DMA(N), .DATA_WIDTH(DW), .LVL_WIDTH(LW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .igr_valid(igr_valid), .igr_ready(igr_ready), .igr_data(igr_data),
    .igr_sop(igr_sop), .igr_eop(igr_eop), .igr_dest(igr_dest),
    .egr_valid(egr_valid), .egr_ready(egr_ready), .egr_data(egr_data),
    .egr_sop(egr_sop), .egr_eop(egr_eop), .egr_dest(egr_dest),
    .q_fill_lvl(q_fill_lvl), .cfg_drop_en(cfg_drop_en), .cfg_drop_threshold(cfg_drop_threshold),
    .stat_drop_cnt(stat_drop_cnt), .stat_pass_cnt(stat_pass_cnt),
    .stat_bad_dest_cnt(stat_bad_dest_cnt)
  );

  dma_rx_dmux_drop_ctrl #(.NUM_DMA(N), .DATA_WIDTH(DW), .LVL_WIDTH(LW), .CNT_WIDTH(SW)) dut_sat (
    .clk(clk), .rst(rst),
    .igr_valid(igr_valid), .igr_ready(s_igr_ready), .igr_data(igr_data),
    .igr_sop(igr_sop), .igr_eop(igr_eop), .igr_dest(igr_dest),
    .egr_valid(s_egr_valid), .egr_ready(egr_ready), .egr_data(s_egr_data),
    .egr_sop(s_egr_sop), .egr_eop(s_egr_eop), .egr_dest(s_egr_dest),
    .q_fill_lvl(q_fill_lvl), .cfg_drop_en(cfg_drop_en), .cfg_drop_threshold(cfg_drop_threshold),
    .stat_drop_cnt(s_drop_cnt), .stat_pass_cnt(s_pass_cnt),
    .stat_bad_dest_cnt(s_bad_cnt)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
    logic [2:0]    dest;
  } beat_t;

  beat_t         exp_q[$];
  int            errors = 0;
  int            checks = 0;
  bit            toggle_rdy = 1'b0;
  logic [CW-1:0] m_pass[N];
  logic [CW-1:0] m_drop[N];
  logic [CW-1:0] m_bad;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic [SW-1:0] sat(input logic [CW-1:0] v);
    return (v > CW'(3)) ? SW'(3) : v[SW-1:0];
  endfunction

  // Egress monitor: every handshake must match the head of the scoreboard
  always @(negedge clk) begin
    if (egr_valid === 1'b1 && egr_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL egr_unexpected: got data %0h dest %0d expected no beat", egr_data, egr_dest);
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        chk("egr_data", egr_data, e.data);
        chk("egr_sop",  DW'(egr_sop), DW'(e.sop));
        chk("egr_eop",  DW'(egr_eop), DW'(e.eop));
        chk("egr_dest", DW'(egr_dest), DW'(e.dest));
      end
    end
  end

  initial begin
    egr_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (toggle_rdy) egr_ready = ~egr_ready;
      else            egr_ready = 1'b1;
    end
  end

  // Present one beat until it is taken; optionally it must be taken at once.
  task automatic send_beat(input logic [DW-1:0] d, input bit s, input bit e, input logic [2:0] dst,
                           input bit exp_pass, input bit ready_now, input string tag);
    int waits = 0;
    igr_valid = 1'b1;
    igr_data  = d;
    igr_sop   = s;
    igr_eop   = e;
    igr_dest  = dst;
    if (exp_pass) exp_q.push_back('{data: d, sop: s, eop: e, dest: dst});
    forever begin
      @(negedge clk);
      if (igr_ready === 1'b1) break;
      waits++;
      if (waits > 40) begin
        checks++;
        errors++;
        $display("FAIL %s_timeout: got igr_ready=0 for %0d cycles expected acceptance", tag, waits);
        break;
      end
    end
    if (ready_now) chk({tag, "_ready_now"}, DW'(waits), DW'(0));
    @(posedge clk);
    #1;
    igr_valid = 1'b0;
  endtask

  task automatic send_pkt(input logic [2:0] dst, input int nbeats, input logic [DW-1:0] base,
                          input bit exp_pass, input bit ready_now, input string tag);
    for (int b = 0; b < nbeats; b++)
      send_beat(base + DW'(b), b == 0, b == nbeats - 1, dst, exp_pass, ready_now, tag);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_counters(input string tag);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("%s_pass%0d", tag, i), DW'(stat_pass_cnt[i*CW +: CW]), DW'(m_pass[i]));
      chk($sformatf("%s_drop%0d", tag, i), DW'(stat_drop_cnt[i*CW +: CW]), DW'(m_drop[i]));
      chk($sformatf("%s_satpass%0d", tag, i), DW'(s_pass_cnt[i*SW +: SW]), DW'(sat(m_pass[i])));
      chk($sformatf("%s_satdrop%0d", tag, i), DW'(s_drop_cnt[i*SW +: SW]), DW'(sat(m_drop[i])));
    end
    chk({tag, "_bad"}, DW'(stat_bad_dest_cnt), DW'(m_bad));
    chk({tag, "_satbad"}, DW'(s_bad_cnt), DW'(sat(m_bad)));
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      m_pass[i] = '0;
      m_drop[i] = '0;
    end
    m_bad              = '0;
    rst                = 1'b1;
    q_fill_lvl         = '0;
    cfg_drop_en        = '0;
    cfg_drop_threshold = '0;
    // A SOP offered during reset must not be accepted
    igr_valid = 1'b1;
    igr_sop   = 1'b1;
    igr_eop   = 1'b1;
    igr_dest  = 3'd1;
    igr_data  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_igr_ready", DW'(igr_ready), DW'(0));
    chk("rst_egr_valid", DW'(egr_valid), DW'(0));
    check_counters("rst");
    @(posedge clk);
    #1;
    igr_valid = 1'b0;
    rst       = 1'b0;
    idle(2);

    // Plain forward on channel 1
    send_pkt(3'd1, 3, 64'hA100, 1'b1, 1'b0, "t1");
    m_pass[1] = 1;
    check_counters("t1");

    // Channel 0 at threshold: sink the whole packet, then one below passes
    cfg_drop_en                 = 3'b001;
    cfg_drop_threshold[0 +: LW] = 16'd100;
    q_fill_lvl[0 +: LW]         = 16'd100;
    idle(3);
    send_pkt(3'd0, 4, 64'hB000, 1'b0, 1'b1, "t2drop");
    m_drop[0] = 1;
    check_counters("t2a");
    q_fill_lvl[0 +: LW] = 16'd99;
    idle(3);
    send_pkt(3'd0, 2, 64'hB100, 1'b1, 1'b0, "t2pass");
    m_pass[0] = 1;
    check_counters("t2b");

    // Out-of-range destination
    send_pkt(3'd5, 2, 64'hC000, 1'b0, 1'b1, "t3");
    m_bad = 1;
    check_counters("t3");

    // Stray non-SOP beat in IDLE is discarded without counting
    send_beat(64'hD000, 1'b0, 1'b0, 3'd1, 1'b0, 1'b1, "t4");
    check_counters("t4");

    // Back-to-back single-beat packets, no bubbles allowed
    send_pkt(3'd0, 1, 64'hE000, 1'b1, 1'b1, "t5a");
    send_pkt(3'd2, 1, 64'hE001, 1'b1, 1'b1, "t5b");
    send_pkt(3'd0, 1, 64'hE002, 1'b1, 1'b1, "t5c");
    send_pkt(3'd2, 1, 64'hE003, 1'b1, 1'b1, "t5d");
    m_pass[0] = 3;
    m_pass[2] = 2;
    check_counters("t5");

    // Egress backpressure toggling, then a CSR change mid-packet
    toggle_rdy = 1'b1;
    send_pkt(3'd2, 5, 64'hF000, 1'b1, 1'b0, "t6a");
    send_beat(64'hF100, 1'b1, 1'b0, 3'd2, 1'b1, 1'b0, "t6b");
    send_beat(64'hF101, 1'b0, 1'b0, 3'd2, 1'b1, 1'b0, "t6b");
    cfg_drop_en                  = 3'b101;
    cfg_drop_threshold[2*LW +: LW] = 16'd0;
    send_beat(64'hF102, 1'b0, 1'b0, 3'd2, 1'b1, 1'b0, "t6b");
    send_beat(64'hF103, 1'b0, 1'b0, 3'd2, 1'b1, 1'b0, "t6b");
    send_beat(64'hF104, 1'b0, 1'b1, 3'd2, 1'b1, 1'b0, "t6b");
    toggle_rdy = 1'b0;
    idle(2);
    m_pass[2] = 4;
    check_counters("t6");

    // Threshold 0 drops everything on channel 2; small counters saturate
    for (int k = 0; k < 4; k++)
      send_pkt(3'd2, 2, 64'h1_0000 + DW'(k * 16), 1'b0, 1'b1, "t7");
    m_drop[2] = 4;
    check_counters("t7");

    // Reset in the middle of a forwarded packet
    send_beat(64'h2000, 1'b1, 1'b0, 3'd1, 1'b1, 1'b0, "t8");
    send_beat(64'h2001, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0, "t8");
    igr_valid = 1'b1;
    igr_data  = 64'h2002;
    igr_sop   = 1'b0;
    igr_eop   = 1'b1;
    igr_dest  = 3'd1;
    rst       = 1'b1;
    @(negedge clk);
    chk("t8_rst_igr_ready", DW'(igr_ready), DW'(0));
    chk("t8_rst_egr_valid", DW'(egr_valid), DW'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t8_after_egr_valid", DW'(egr_valid), DW'(0));
    chk("t8_after_igr_ready", DW'(igr_ready), DW'(1));
    @(posedge clk);
    #1;
    igr_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      m_pass[i] = '0;
      m_drop[i] = '0;
    end
    m_bad = '0;
    check_counters("t8");
    send_pkt(3'd1, 1, 64'h3000, 1'b1, 1'b1, "t9");
    m_pass[1] = 1;
    check_counters("t9");

    idle(3);
    chk("scoreboard_empty", DW'(exp_q.size()), DW'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no completion expected finish");
    $fatal(1, "timeout");
  end

endmodule
